// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size codes, FSM states,
// wait-counter width and the alignment rule used when DMEM_MISALIGN_EXC_EN is set.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Holds WAIT_CYCLES in the range 0..15.
  localparam int CNT_W = 4;

  function automatic logic is_misaligned(size_e size, logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// Little-endian lane steering: byte-enable mask and replicated store data for
// writes, lane extraction with sign/zero extension for loads.
module dmem_lane_sel
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    byte_en  = 4'b1111;
    wword    = wdata;
    rdata    = rword;
    byte_sel = 8'h00;
    half_sel = 16'h0000;

    case (lane)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = lane[1] ? rword[31:16] : rword[15:0];

    // Misaligned halves and words fall onto their aligned lanes here.
    unique case (size_e'(size))
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wword   = {4{wdata[7:0]}};
        rdata   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        rdata   = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: one request at a time, fixed wait
// states, response held until taken. Optional DMEM_MISALIGN_EXC_EN flags misaligned accesses.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs;
  logic             do_access;

  logic             lat_we, lat_signed;
  logic [1:0]       lat_size;
  logic [11:0]      lat_addr;
  logic [31:0]      lat_wdata;

  logic             acc_we, acc_signed, acc_err;
  logic [1:0]       acc_size;
  logic [11:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [IDX_W-1:0] acc_idx;

  logic [3:0]       byte_en;
  logic [31:0]      wword;
  logic [31:0]      ld_data;

  logic [31:0]      mem [DEPTH_WORDS];

  assign req_ready = (state_q == ST_IDLE) && rst;
  assign busy      = (state_q != ST_IDLE);
  assign hs        = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The access fires in the wait cycle whose decrement reaches zero,
        // so exactly WAIT_CYCLES wait cycles separate accept and response.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_signed <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (hs) begin
      lat_we     <= req_we;
      lat_signed <= req_signed;
      lat_size   <= req_size;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // A zero-wait access happens on the accept edge, before anything is latched.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we     = req_we;
      acc_signed = req_signed;
      acc_size   = req_size;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = lat_we;
      acc_signed = lat_signed;
      acc_size   = lat_size;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end
  end

  assign acc_idx = IDX_W'(32'(acc_addr[11:2]) % 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_EXC_EN
  assign acc_err = is_misaligned(size_e'(acc_size), acc_addr[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  dmem_lane_sel u_lane_sel (
    .size     (acc_size),
    .sign_ext (acc_signed),
    .lane     (acc_addr[1:0]),
    .wdata    (acc_wdata),
    .rword    (mem[acc_idx]),
    .byte_en  (byte_en),
    .wword    (wword),
    .rdata    (ld_data)
  );

  // NOTE: storage is deliberately left out of reset; only the control path restarts.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (do_access) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (acc_we || acc_err) ? 32'h0 : ld_data;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err <= 1'b0;
    end else if (do_access) begin
      rsp_err <= acc_err;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, each checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [11:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        busy       [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [11:0] a, logic [1:0] sz, bit sg);
    logic [31:0] v;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      v  = (w >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_merge(logic [31:0] w, logic [11:0] a, logic [1:0] sz, logic [31:0] wd);
    logic [31:0] m;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'hFF << sh;
      return (w & ~m) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      m  = 32'hFFFF << sh;
      return (w & ~m) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit misaligned(logic [11:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_EXC_EN
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : 0;

    dmem_resp #(.WAIT_CYCLES(W), .DEPTH_WORDS(1024)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_size   (req_size[g]),
      .req_signed (req_signed[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .busy       (busy[g])
    );

    // Model: a request occupies the responder from its accept edge until its
    // response is taken; the access happens W edges after the accept edge.
    logic [31:0] m_mem [1024];
    bit          m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    int          m_edge = 0, m_due = 0;
    bit          t_we, t_sg;
    logic [1:0]  t_sz;
    logic [11:0] t_a;
    logic [31:0] t_wd;

    initial forever begin
      @(posedge clk or negedge rst[g]);
      if (!rst[g]) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else begin
        m_edge++;
        if (m_valid) begin
          if (rsp_ready[g]) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
          end
        end else if (!m_busy && req_valid[g]) begin
          t_we = req_we[g]; t_sg = req_signed[g]; t_sz = req_size[g];
          t_a  = req_addr[g]; t_wd = req_wdata[g];
          m_busy = 1'b1;
          m_due  = m_edge + W;
        end
        if (m_busy && !m_valid && m_edge == m_due) begin
          m_valid = 1'b1;
          if (misaligned(t_a, t_sz)) begin
            m_err = 1'b1; m_rdata = 32'h0;
          end else begin
            m_err = 1'b0;
            if (t_we) begin
              m_mem[t_a[11:2]] = st_merge(m_mem[t_a[11:2]], t_a, t_sz, t_wd);
              m_rdata = 32'h0;
            end else begin
              m_rdata = ld_ext(m_mem[t_a[11:2]], t_a, t_sz, t_sg);
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("req_ready", g, 32'(req_ready[g]), 32'(rst[g] && !m_busy));
        check("rsp_valid", g, 32'(rsp_valid[g]), 32'(m_valid));
        check("busy",      g, 32'(busy[g]),      32'(m_busy));
        if (m_valid) begin
          check("rsp_rdata", g, rsp_rdata[g], m_rdata);
          check("rsp_err",   g, 32'(rsp_err[g]), 32'(m_err));
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge that follows
  // the completion edge. With hold>0 the next request is pre-asserted during RESP.
  task automatic txn(int id, bit we, logic [1:0] sz, bit sg, logic [11:0] a, logic [31:0] wd,
                     int hold, output logic [31:0] rd, output bit err,
                     output int lat, output int acc_wait);
    req_we[id] = we; req_size[id] = sz; req_signed[id] = sg;
    req_addr[id] = a; req_wdata[id] = wd; req_valid[id] = 1'b1;
    rsp_ready[id] = (hold == 0);
    acc_wait = 0;
    while (!req_ready[id] && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    check("accept", id, 32'(req_ready[id]), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[id] && lat < 40);
    check("rsp_seen", id, 32'(rsp_valid[id]), 32'd1);
    rd  = rsp_rdata[id];
    err = rsp_err[id];
    for (int i = 0; i < hold; i++) begin
      req_valid[id] = 1'b1;
      @(negedge clk);
      check("hold_no_accept", id, 32'(req_ready[id]), 32'd0);
    end
    rsp_ready[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          sg;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14] = '{
    '{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 32'h0000_0000},
    '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         32'hDEAD_BEEF},
    '{1'b1, 2'b00, 1'b0, 12'h013, 32'h0000_007F, 32'h0000_0000},
    '{1'b0, 2'b00, 1'b1, 12'h013, 32'h0,         32'h0000_007F},
    '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         32'h7FAD_BEEF},
    '{1'b0, 2'b00, 1'b0, 12'h012, 32'h0,         32'h0000_00AD},
    '{1'b0, 2'b00, 1'b1, 12'h012, 32'h0,         32'hFFFF_FFAD},
    '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,         32'h0000_7FAD},
    '{1'b0, 2'b01, 1'b1, 12'h010, 32'h0,         32'hFFFF_BEEF},
    '{1'b0, 2'b01, 1'b0, 12'h010, 32'h0,         32'h0000_BEEF},
    '{1'b0, 2'b11, 1'b0, 12'h010, 32'h0,         32'h7FAD_BEEF},
    '{1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF_1234, 32'h0000_0000},
    '{1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFF_FF55, 32'h0000_0000},
    '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         32'h1234_55EF}
  };

`ifdef DMEM_MISALIGN_EXC_EN
  localparam logic        MIS_ERR  = 1'b1;
  localparam logic [31:0] MIS_WORD = 32'h1122_3344;
`else
  localparam logic        MIS_ERR  = 1'b0;
  localparam logic [31:0] MIS_WORD = 32'h1122_BEEF;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          err;
    int          lat, aw;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b10;
      req_signed[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", i, 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      check("rst_busy",      i, 32'(busy[i]),      32'd0);
      check("rst_rsp_rdata", i, rsp_rdata[i],      32'd0);
      check("rst_rsp_err",   i, 32'(rsp_err[i]),   32'd0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Word/byte/half stores and loads with WAIT_CYCLES=2.
    foreach (vecs[k]) begin
      txn(0, vecs[k].we, vecs[k].sz, vecs[k].sg, vecs[k].a, vecs[k].wd, 0, rd, err, lat, aw);
      check("vec_rdata", k, rd, vecs[k].exp);
      check("vec_latency", k, 32'(lat), 32'd3);
    end

    // Response held off for 5 cycles; the pre-asserted next load is taken right after release.
    txn(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5, rd, err, lat, aw);
    check("hold_rdata", 0, rd, 32'h1234_55EF);
    txn(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, err, lat, aw);
    check("next_accept_wait", 0, 32'(aw), 32'd0);
    check("next_rdata", 0, rd, 32'h1234_55EF);

    // Reset during the wait of a store drops it.
    txn(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFE_F00D, 0, rd, err, lat, aw);
    txn(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 0, rd, err, lat, aw);
    check("pre_rst_rdata", 0, rd, 32'hCAFE_F00D);
    req_we[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 12'h020;
    req_wdata[0] = 32'h1234_5678; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("in_wait_busy", 0, 32'(busy[0]), 32'd1);
    #2 rst[0] = 1'b0;
    #1;
    check("midrst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    check("midrst_busy",      0, 32'(busy[0]),      32'd0);
    check("midrst_req_ready", 0, 32'(req_ready[0]), 32'd0);
    check("midrst_rsp_rdata", 0, rsp_rdata[0],      32'd0);
    check("midrst_rsp_err",   0, 32'(rsp_err[0]),   32'd0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 0, rd, err, lat, aw);
    check("post_rst_old_data", 0, rd, 32'hCAFE_F00D);

    // Misaligned halfword store.
    txn(0, 1'b1, 2'b10, 1'b0, 12'h030, 32'h1122_3344, 0, rd, err, lat, aw);
    txn(0, 1'b1, 2'b01, 1'b0, 12'h031, 32'h0000_BEEF, 0, rd, err, lat, aw);
    check("mis_err", 0, 32'(err), 32'(MIS_ERR));
    check("mis_rdata", 0, rd, 32'h0);
    check("mis_latency", 0, 32'(lat), 32'd3);
    txn(0, 1'b0, 2'b10, 1'b0, 12'h030, 32'h0, 0, rd, err, lat, aw);
    check("mis_word", 0, rd, MIS_WORD);

    // Zero-wait instance, back-to-back.
    check("w0_idle_busy", 1, 32'(busy[1]), 32'd0);
    txn(1, 1'b1, 2'b10, 1'b0, 12'h040, 32'hA5A5_5A5A, 0, rd, err, lat, aw);
    check("w0_st_latency", 1, 32'(lat), 32'd1);
    txn(1, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 0, rd, err, lat, aw);
    check("w0_ld_latency", 1, 32'(lat), 32'd1);
    check("w0_ld_rdata", 1, rd, 32'hA5A5_5A5A);
    txn(1, 1'b0, 2'b00, 1'b1, 12'h043, 32'h0, 0, rd, err, lat, aw);
    check("w0_lb_rdata", 1, rd, 32'hFFFF_FFA5);
    txn(1, 1'b0, 2'b00, 1'b0, 12'h041, 32'h0, 0, rd, err, lat, aw);
    check("w0_lbu_rdata", 1, rd, 32'h0000_005A);
    check("w0_aw", 1, 32'(aw), 32'd0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
